// File: rtl/vec3_addsub_stream.sv
// Three-lane fp32 vector add/subtract with tag sideband.
// A credit-gated output FIFO makes backpressure lossless.
package vec3_addsub_stream_pkg;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vec3_t;
endpackage

module fp32_add #(
  parameter string USE_DSP = "MED",
  parameter int    LATENCY = 8
) (
  input  logic        clk,
  input  logic        op_vld,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        result_vld,
  output logic [31:0] result
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam bit IN_REG =
    (USE_DSP != "NONE") && (LATENCY > 1);
  localparam int TAIL = IN_REG ? LATENCY - 1 : LATENCY;

  function automatic logic [31:0] fp_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic        big_a;
    logic        s_h;
    logic        s_l;
    logic [7:0]  e_h;
    logic [7:0]  e_l;
    logic [7:0]  d;
    logic [26:0] m_h;
    logic [26:0] m_l;
    logic [26:0] m_s;
    logic [26:0] lost;
    logic [27:0] sum;
    logic [24:0] m_r;
    int          e;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && a[22:0] != '0) return QNAN;
      if (b[30:23] == 8'hFF && b[22:0] != '0) return QNAN;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF &&
          a[31] != b[31]) return QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    // Subnormal inputs are flushed to zero.
    if (a[30:23] == '0)
      return (b[30:23] == '0) ? {a[31] & b[31], 31'd0} : b;
    if (b[30:23] == '0) return a;
    big_a = a[30:0] >= b[30:0];
    s_h = big_a ? a[31] : b[31];
    s_l = big_a ? b[31] : a[31];
    e_h = big_a ? a[30:23] : b[30:23];
    e_l = big_a ? b[30:23] : a[30:23];
    m_h = {1'b1, big_a ? a[22:0] : b[22:0], 3'b000};
    m_l = {1'b1, big_a ? b[22:0] : a[22:0], 3'b000};
    d = e_h - e_l;
    if (d > 8'd26) begin
      m_s = 27'd1;
    end else begin
      lost = m_l & ((27'd1 << d) - 27'd1);
      m_s = (m_l >> d) | {26'd0, lost != '0};
    end
    if (s_h == s_l) sum = {1'b0, m_h} + {1'b0, m_s};
    else sum = {1'b0, m_h} - {1'b0, m_s};
    if (sum == '0) return 32'd0;
    e = int'(e_h);
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26]) begin
        sum = sum << 1;
        e = e - 1;
      end
    end
    m_r = {1'b0, sum[26:3]} +
          {24'd0, sum[2] & (sum[3] | sum[1] | sum[0])};
    if (m_r[24]) begin
      m_r = m_r >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s_h, 8'hFF, 23'd0};
    if (e <= 0) return {s_h, 31'd0};
    return {s_h, e[7:0], m_r[22:0]};
  endfunction

  logic        s_vld;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        vld_q [TAIL];
  logic [31:0] res_q [TAIL];

  if (IN_REG) begin : g_in_reg
    logic        v_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    always_ff @(posedge clk) begin
      v_q <= op_vld;
      a_q <= op_a;
      b_q <= op_b;
    end
    assign s_vld = v_q;
    assign s_a   = a_q;
    assign s_b   = b_q;
  end else begin : g_in_comb
    assign s_vld = op_vld;
    assign s_a   = op_a;
    assign s_b   = op_b;
  end

  // Pipeline is intentionally unreset; the wrapper blanks it.
  always_ff @(posedge clk) begin
    vld_q[0] <= s_vld;
    res_q[0] <= fp_add(s_a, s_b);
    for (int i = 1; i < TAIL; i++) begin
      vld_q[i] <= vld_q[i-1];
      res_q[i] <= res_q[i-1];
    end
  end

  assign result_vld = vld_q[TAIL-1];
  assign result     = res_q[TAIL-1];
endmodule

module vec3_addsub_stream
  import vec3_addsub_stream_pkg::*;
#(
  parameter string USE_DSP     = "MED",
  parameter int    ADD_LATENCY = 8,
  parameter int    FIFO_DEPTH  = 16,
  parameter int    TAG_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             op_sub,
  input  vec3_t            a,
  input  vec3_t            b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  input  logic             out_rdy,
  output vec3_t            result,
  output logic [TAG_W-1:0] out_tag,
  output logic             lane_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(ADD_LATENCY + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(ADD_LATENCY);

  typedef struct packed {
    vec3_t            res;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic accept;
  logic pop;
  logic push;
  logic unblanked;
  vec3_t b_eff;
  vec3_t res_v;
  logic res_vld_x;
  logic res_vld_y;
  logic res_vld_z;
  logic [31:0] res_x;
  logic [31:0] res_y;
  logic [31:0] res_z;
  entry_t head;

  logic [CW-1:0] credits_q, credits_d;
  logic [BW-1:0] blank_q, blank_d;
  logic lane_err_q, lane_err_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADD_LATENCY-1:0] tvld_q, tvld_d;
  logic [TAG_W-1:0] tag_q [ADD_LATENCY];
  logic [TAG_W-1:0] tag_d [ADD_LATENCY];
  entry_t mem_q [FIFO_DEPTH];

  assign unblanked = blank_q == '0;
  assign in_rdy    = (credits_q != '0) && unblanked;
  assign accept    = in_vld && in_rdy;
  assign out_vld   = cnt_q != '0;
  assign pop       = out_vld && out_rdy;
  assign push      = res_vld_x && tvld_q[ADD_LATENCY-1] &&
                     unblanked;
  assign head      = mem_q[rd_q];
  assign result    = head.res;
  assign out_tag   = head.tag;
  assign lane_err  = lane_err_q;
  assign res_v     = '{x: res_x, y: res_y, z: res_z};

  always_comb begin
    b_eff = b;
    if (op_sub) begin
      b_eff.x[31] = ~b.x[31];
      b_eff.y[31] = ~b.y[31];
      b_eff.z[31] = ~b.z[31];
    end
  end

  fp32_add #(.USE_DSP(USE_DSP), .LATENCY(ADD_LATENCY)) u_x (
    .clk(clk), .op_vld(accept), .op_a(a.x), .op_b(b_eff.x),
    .result_vld(res_vld_x), .result(res_x)
  );
  fp32_add #(.USE_DSP(USE_DSP), .LATENCY(ADD_LATENCY)) u_y (
    .clk(clk), .op_vld(accept), .op_a(a.y), .op_b(b_eff.y),
    .result_vld(res_vld_y), .result(res_y)
  );
  fp32_add #(.USE_DSP(USE_DSP), .LATENCY(ADD_LATENCY)) u_z (
    .clk(clk), .op_vld(accept), .op_a(a.z), .op_b(b_eff.z),
    .result_vld(res_vld_z), .result(res_z)
  );

  always_comb begin
    tvld_d[0] = accept;
    tag_d[0]  = accept ? in_tag : tag_q[0];
    for (int i = 1; i < ADD_LATENCY; i++) begin
      tvld_d[i] = tvld_q[i-1];
      tag_d[i]  = tvld_q[i-1] ? tag_q[i-1] : tag_q[i];
    end
  end

  always_comb begin
    credits_d = credits_q;
    if (accept && !pop) credits_d = credits_q - CW'(1);
    else if (!accept && pop) credits_d = credits_q + CW'(1);
    blank_d = unblanked ? blank_q : blank_q - BW'(1);
    lane_err_d = lane_err_q | (unblanked &&
      ((res_vld_y != res_vld_x) || (res_vld_z != res_vld_x)));
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
    if (pop) rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits_q  <= CRED_MAX;
      blank_q    <= BLANK_INIT;
      lane_err_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      tvld_q     <= '0;
      tag_q      <= '{default: '0};
    end else begin
      credits_q  <= credits_d;
      blank_q    <= blank_d;
      lane_err_q <= lane_err_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      tvld_q     <= tvld_d;
      tag_q      <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {res_v, tag_q[ADD_LATENCY-1]};
  end
endmodule

// File: tb/tb_vec3_addsub_stream.sv
// Bench for vec3_addsub_stream: integer-valued fp32 operands
// so expected sums come from exact integer arithmetic.
module tb_vec3_addsub_stream;
  import vec3_addsub_stream_pkg::*;

  localparam int L  = 8;
  localparam int D  = 16;
  localparam int TW = 8;

  typedef struct {
    logic [31:0]   x;
    logic [31:0]   y;
    logic [31:0]   z;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_vld;
  logic in_rdy;
  logic op_sub;
  vec3_t a;
  vec3_t b;
  logic [TW-1:0] in_tag;
  logic out_vld;
  logic out_rdy;
  vec3_t result;
  logic [TW-1:0] out_tag;
  logic lane_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pops = 0;
  int last_acc = 0;
  int out_cnt = 0;
  int ai [3];
  int bi [3];
  exp_t exp_q[$];
  int pop_cyc[$];
  logic prev_hold = 1'b0;
  vec3_t prev_res;
  logic [TW-1:0] prev_tag;

  vec3_addsub_stream #(
    .USE_DSP("MED"), .ADD_LATENCY(L),
    .FIFO_DEPTH(D), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .op_sub(op_sub), .a(a), .b(b), .in_tag(in_tag),
    .out_vld(out_vld), .out_rdy(out_rdy), .result(result),
    .out_tag(out_tag), .lane_err(lane_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] i2f(input int v);
    int m;
    int p;
    logic s;
    if (v == 0) return 32'h0;
    s = v < 0;
    m = s ? -v : v;
    p = 0;
    for (int k = 0; k < 30; k++) if (m >= (1 << k)) p = k;
    return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h7F_FFFF)};
  endfunction

  function automatic int rnd_int();
    if ($urandom_range(0, 9) == 0) return 0;
    return int'($urandom_range(0, 2097152)) - 1048576;
  endfunction

  task automatic set_req(input int ax, input int ay,
                         input int az, input int bx,
                         input int by, input int bz,
                         input bit op, input logic [TW-1:0] t);
    ai[0] = ax; ai[1] = ay; ai[2] = az;
    bi[0] = bx; bi[1] = by; bi[2] = bz;
    a = '{x: i2f(ax), y: i2f(ay), z: i2f(az)};
    b = '{x: i2f(bx), y: i2f(by), z: i2f(bz)};
    op_sub = op;
    in_tag = t;
    in_vld = 1'b1;
  endtask

  task automatic rnd_req(input logic [TW-1:0] t);
    int x;
    x = rnd_int();
    set_req(x, rnd_int(), rnd_int(),
            ($urandom_range(0, 4) == 0) ? x : rnd_int(),
            rnd_int(), rnd_int(),
            1'($urandom_range(0, 1)), t);
  endtask

  // Model and checker: expected results in accept order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_lane_err", lane_err, 0);
    end else begin
      if (prev_hold) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_res", result, prev_res);
        chk("hold_tag", out_tag, prev_tag);
      end
      if (out_vld) begin
        out_cnt++;
        chk("exp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("res_x", result.x, exp_q[0].x);
          chk("res_y", result.y, exp_q[0].y);
          chk("res_z", result.z, exp_q[0].z);
          chk("res_tag", out_tag, exp_q[0].tag);
          if (out_rdy) begin
            void'(exp_q.pop_front());
            pops++;
            pop_cyc.push_back(cyc);
          end
        end
      end
      prev_hold = out_vld && !out_rdy;
      prev_res = result;
      prev_tag = out_tag;
      if (in_vld && in_rdy) begin
        exp_t e;
        e.x = i2f(op_sub ? ai[0] - bi[0] : ai[0] + bi[0]);
        e.y = i2f(op_sub ? ai[1] - bi[1] : ai[1] + bi[1]);
        e.z = i2f(op_sub ? ai[2] - bi[2] : ai[2] + bi[2]);
        e.tag = in_tag;
        exp_q.push_back(e);
        acc_cnt++;
        last_acc = cyc;
      end
    end
  end

  task automatic release_rst();
    int k;
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (in_rdy || k > L + 4) break;
      k++;
    end
    chk("rdy_after_rst", k, L);
  endtask

  task automatic wait_out_lat(input string nm, input int t0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_vld) break;
    end
    chk(nm, cyc - t0, L + 1);
  endtask

  initial begin
    int n0;
    int p0;
    int o0;
    int fall_at;
    int drops;
    in_vld = 1'b0;
    op_sub = 1'b0;
    a = '0;
    b = '0;
    in_tag = '0;
    out_rdy = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    release_rst();

    // Directed add and subtract with literal results.
    @(posedge clk); #1;
    set_req(1, 2, 3, 2, 1, -1, 1'b0, 8'h5A);
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_out_lat("add_lat", last_acc);
    chk("add_res", result,
        {32'h4040_0000, 32'h4040_0000, 32'h4000_0000});
    chk("add_tag", out_tag, 8'h5A);
    @(posedge clk); #1;
    set_req(1, 2, 3, 2, 1, -1, 1'b1, 8'hA5);
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_out_lat("sub_lat", last_acc);
    chk("sub_res", result,
        {32'hBF80_0000, 32'h3F80_0000, 32'h4080_0000});
    chk("sub_tag", out_tag, 8'hA5);

    // Backpressure: 20 back-to-back requests into a stalled sink.
    @(posedge clk); #1;
    out_rdy = 1'b0;
    n0 = acc_cnt;
    fall_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!in_rdy && fall_at < 0) fall_at = acc_cnt - n0;
      rnd_req(TW'(i));
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    chk("bp_accepts", acc_cnt - n0, D);
    chk("bp_rdy_fall", fall_at, D);
    repeat (L + 4) @(posedge clk);
    #1;
    chk("bp_full_vld", out_vld, 1);
    chk("bp_full_rdy", in_rdy, 0);
    p0 = pops;
    out_rdy = 1'b1;
    repeat (D + L + 5) @(posedge clk);
    #1;
    chk("bp_drained", pops - p0, D);
    chk("bp_empty", exp_q.size(), 0);

    // Streaming at full rate.
    n0 = acc_cnt;
    p0 = pops;
    drops = 0;
    pop_cyc.delete();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!in_rdy) drops++;
      rnd_req(TW'(i));
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (L + 5) @(posedge clk);
    #1;
    chk("st_rdy_drops", drops, 0);
    chk("st_accepts", acc_cnt - n0, 100);
    chk("st_pops", pops - p0, 100);
    chk("st_span", pop_cyc[$] - pop_cyc[0], 99);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      rnd_req(TW'($urandom_range(0, 255)));
      in_vld = $urandom_range(0, 9) < 7;
      out_rdy = $urandom_range(0, 9) < 6;
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    repeat (D + L + 10) @(posedge clk);
    #1;
    chk("rnd_drain", exp_q.size(), 0);

    // Reset with five operations in flight.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rnd_req(TW'(8'hE0 + i));
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    release_rst();
    o0 = out_cnt;
    repeat (D + L + 5) @(posedge clk);
    #1;
    chk("rst_no_out", out_cnt - o0, 0);

    // Lane desynchronisation.
    @(posedge clk); #1;
    chk("lerr_pre", lane_err, 0);
    force dut.res_vld_y = 1'b1;
    @(posedge clk); #1;
    release dut.res_vld_y;
    chk("lerr_set", lane_err, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("lerr_hold", lane_err, 1);
    rst = 1'b1;
    #1;
    chk("lerr_clr", lane_err, 0);
    repeat (2) @(posedge clk);
    release_rst();

    // Traffic still flows after the reset.
    @(posedge clk); #1;
    set_req(7, -7, 100, 7, 3, -50, 1'b1, 8'h33);
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_out_lat("post_lat", last_acc);
    chk("post_res", result,
        {32'h0000_0000, 32'hC120_0000, 32'h4316_0000});
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vec3_addsub_stream.md
VEC3_ADDSUB_STREAM -- requirements
Module: vec3_addsub_stream

Interface
REQ-001 SHALL have parameter USE_DSP, default MED; DSP usage passed unchanged to all three fp32_add lanes.
REQ-002 SHALL have parameter ADD_LATENCY, default 8; the fixed op_vld-to-result_vld latency of fp32_add, in cycles, at the chosen USE_DSP.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16; output buffer entries, legal range ADD_LATENCY+1 to 64.
REQ-004 SHALL have parameter TAG_W, default 8; width of the sideband tag.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port in_vld, input, 1, operand pair valid.
REQ-008 SHALL have port in_rdy, output, 1, block can accept an operand pair.
REQ-009 SHALL have port op_sub, input, 1, 0 = a+b, 1 = a-b; sampled on accept.
REQ-010 SHALL have ports a and b, input, vec3_t, operands.
REQ-011 SHALL have port in_tag, input, TAG_W, sideband tag; sampled on accept.
REQ-012 SHALL have port out_vld, output, 1, result valid.
REQ-013 SHALL have port out_rdy, input, 1, consumer accepts the result.
REQ-014 SHALL have port result, output, vec3_t, per-lane sum or difference.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the result being presented.
REQ-016 SHALL have port lane_err, output, 1, sticky lane-desynchronisation flag.

Function
REQ-017 SHALL define accept as in_vld&&in_rdy, and SHALL drive op_vld of all three lanes with accept in the same cycle.
REQ-018 SHALL, when op_sub=1, invert bit 31 of b.x, b.y and b.z before the adders; a, and all other bits of b, SHALL pass unchanged.
REQ-019 SHALL carry in_tag through a valid-qualified delay line of exactly ADD_LATENCY stages, so the tag arrives aligned with the x-lane result_vld.
REQ-020 SHALL push {result, tag} into a FIFO_DEPTH-entry FIFO on every x-lane result_vld that is not blanked (see REQ-027).
REQ-021 SHALL present out_vld, result and out_tag directly from the FIFO head, and SHALL pop the FIFO when out_vld&&out_rdy.
REQ-022 SHALL have an accept-to-output latency of ADD_LATENCY+1 cycles when the FIFO is empty: accept in cycle t, out_vld high in cycle t+ADD_LATENCY+1.
REQ-023 SHALL keep a credit counter, 0 to FIFO_DEPTH: -1 on accept, +1 on pop, unchanged when both happen in one cycle; it SHALL never underflow or overflow.
REQ-024 SHALL drive in_rdy as (credits>0)&&(blank_cnt==0), so a FIFO push can never find the FIFO full.
REQ-025 SHALL keep result, out_tag and out_vld stable while out_vld&&!out_rdy.
REQ-026 SHALL sustain one accept per cycle indefinitely while out_rdy is held high.
REQ-027 SHALL, after reset, run blank_cnt down from ADD_LATENCY to 0 and discard any lane result_vld while blank_cnt!=0, because fp32_add pipelines are not reset and may still hold pre-reset operations.
REQ-028 SHALL set lane_err, and hold it until reset, on any unblanked cycle in which the y-lane or z-lane result_vld differs from the x-lane result_vld.
REQ-029 SHALL handle a simultaneous push and pop on an empty FIFO by going through the FIFO: out_vld rises the cycle after the push, with no combinational bypass.
REQ-030 SHALL make full-FIFO and empty-FIFO boundaries unreachable as error cases; the credit scheme guarantees this.

Reset
REQ-031 SHALL, while rst is high, force out_vld=0, in_rdy=0, lane_err=0, credits=FIFO_DEPTH, FIFO empty, tag delay line invalid and blank_cnt=ADD_LATENCY.
REQ-032 SHALL, on rst assertion mid-stream, discard all FIFO contents and in-flight operations; no pre-reset result SHALL ever appear on out_vld.
REQ-033 SHALL assert in_rdy first in the cycle after blank_cnt reaches 0, which is ADD_LATENCY cycles after rst deassertion.

Verification
REQ-034 SHALL verify add with a=(1.0,2.0,3.0), b=(2.0,1.0,-1.0), tag 0x5A, op_sub=0: result=(0x40400000,0x40400000,0x40000000), out_tag=0x5A, out_vld exactly ADD_LATENCY+1 cycles after accept.
REQ-035 SHALL verify subtract with the same operands and op_sub=1: result=(0xBF800000,0x3F800000,0x40800000).
REQ-036 SHALL verify backpressure: out_rdy=0 and 20 back-to-back requests; in_rdy falls after exactly FIFO_DEPTH accepts; after out_rdy=1, all 16 results drain in order with matching tags and none are lost or duplicated.
REQ-037 SHALL verify streaming: out_rdy=1 and 100 consecutive requests; 100 results at one per cycle, tags 0..99 in order, in_rdy never drops.
REQ-038 SHALL verify reset mid-flight: rst pulsed with 5 operations in flight; no out_vld for those operations; in_rdy high exactly ADD_LATENCY cycles after rst falls.
REQ-039 SHALL verify lane_err: force a one-cycle y-lane result_vld mismatch; lane_err=1 next cycle and stays high until rst.
